// File: rtl/mdp_pkg.sv
// Memory-dependence-prediction shared types: store-set ID width, SSIT index
// width and the SSIT trainer state encoding.
package mdp_pkg;

    localparam int unsigned IDX_W  = 10;
    localparam int unsigned SSID_W = 7;

    typedef logic [SSID_W-1:0] ssid_t;

    typedef enum logic {
        ST_IDLE,
        ST_UPDATE
    } trn_state_e;

    function automatic ssid_t ssid_min(ssid_t a, ssid_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ssit_if.sv
// SSIT bus: four rename-slot lookups, the LSU violation report channel and
// the clear request/strobe shared with the LFST.
interface ssit_if;
    import mdp_pkg::*;

    logic [63:0] inst0_pc_i;
    logic [63:0] inst1_pc_i;
    logic [63:0] inst2_pc_i;
    logic [63:0] inst3_pc_i;
    ssid_t       inst0_ssid_o;
    ssid_t       inst1_ssid_o;
    ssid_t       inst2_ssid_o;
    ssid_t       inst3_ssid_o;
    logic        inst0_ssid_vld_o;
    logic        inst1_ssid_vld_o;
    logic        inst2_ssid_vld_o;
    logic        inst3_ssid_vld_o;
    logic        viol_vld_i;
    logic        viol_rdy_o;
    logic [63:0] viol_ld_pc_i;
    logic [63:0] viol_st_pc_i;
    logic        clear_req_i;
    logic        clear_o;

    modport master (
        output inst0_pc_i, inst1_pc_i, inst2_pc_i, inst3_pc_i,
        output viol_vld_i, viol_ld_pc_i, viol_st_pc_i, clear_req_i,
        input  inst0_ssid_o, inst1_ssid_o, inst2_ssid_o, inst3_ssid_o,
        input  inst0_ssid_vld_o, inst1_ssid_vld_o, inst2_ssid_vld_o, inst3_ssid_vld_o,
        input  viol_rdy_o, clear_o
    );

    modport slave (
        input  inst0_pc_i, inst1_pc_i, inst2_pc_i, inst3_pc_i,
        input  viol_vld_i, viol_ld_pc_i, viol_st_pc_i, clear_req_i,
        output inst0_ssid_o, inst1_ssid_o, inst2_ssid_o, inst3_ssid_o,
        output inst0_ssid_vld_o, inst1_ssid_vld_o, inst2_ssid_vld_o, inst3_ssid_vld_o,
        output viol_rdy_o, clear_o
    );

endinterface

// File: rtl/ssit_clear_timer.sv
// Periodic invalidation timer: fires every CLEAR_PERIOD cycles or on request,
// and registers a one-cycle clear_o strobe for the consumer side.
module ssit_clear_timer #(
    parameter int unsigned CLEAR_PERIOD = 65536
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_req_i,
    output logic clear_fire_o,
    output logic clear_o
);

    localparam int unsigned CNT_W = (CLEAR_PERIOD > 2) ? $clog2(CLEAR_PERIOD) : 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(CLEAR_PERIOD - 1);

    cnt_t cnt_q, cnt_d;
    logic clear_q, clear_d;

    always_comb begin
        clear_fire_o = (cnt_q == CNT_LAST) || clear_req_i;
        cnt_d        = clear_fire_o ? '0 : cnt_q + 1'b1;
        clear_d      = clear_fire_o;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            clear_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
        end
    end

    assign clear_o = clear_q;

endmodule

// File: rtl/ssit.sv
// Store Set ID Table: combinational SSID lookup for four rename slots and a
// two-state trainer applying store-set assignment rules on violation reports.
module ssit #(
    parameter int unsigned IDX_W        = mdp_pkg::IDX_W,
    parameter int unsigned CLEAR_PERIOD = 65536
) (
    input  logic   clock,
    input  logic   reset_n,
    ssit_if.slave  bus
);
    import mdp_pkg::*;

    localparam int unsigned DEPTH = 1 << IDX_W;
    typedef logic [IDX_W-1:0] idx_t;

    ssid_t            ssid_arr_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    trn_state_e state_q, state_d;
    idx_t       ld_idx_q, ld_idx_d;
    idx_t       st_idx_q, st_idx_d;
    ssid_t      alloc_q, alloc_d;

    logic  wr_ld, wr_st;
    ssid_t wr_ssid;
    logic  clear_fire;
    logic  l_vld, s_vld;
    ssid_t l_ssid, s_ssid;

    function automatic idx_t pc_idx(logic [63:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    ssit_clear_timer #(.CLEAR_PERIOD(CLEAR_PERIOD)) u_clear_timer (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_req_i  (bus.clear_req_i),
        .clear_fire_o (clear_fire),
        .clear_o      (bus.clear_o)
    );

    assign bus.inst0_ssid_o     = ssid_arr_q[pc_idx(bus.inst0_pc_i)];
    assign bus.inst1_ssid_o     = ssid_arr_q[pc_idx(bus.inst1_pc_i)];
    assign bus.inst2_ssid_o     = ssid_arr_q[pc_idx(bus.inst2_pc_i)];
    assign bus.inst3_ssid_o     = ssid_arr_q[pc_idx(bus.inst3_pc_i)];
    assign bus.inst0_ssid_vld_o = vld_q[pc_idx(bus.inst0_pc_i)];
    assign bus.inst1_ssid_vld_o = vld_q[pc_idx(bus.inst1_pc_i)];
    assign bus.inst2_ssid_vld_o = vld_q[pc_idx(bus.inst2_pc_i)];
    assign bus.inst3_ssid_vld_o = vld_q[pc_idx(bus.inst3_pc_i)];
    assign bus.viol_rdy_o       = (state_q == ST_IDLE);

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.inst0_pc_i[63:IDX_W+2], bus.inst0_pc_i[1:0],
                              bus.inst1_pc_i[63:IDX_W+2], bus.inst1_pc_i[1:0],
                              bus.inst2_pc_i[63:IDX_W+2], bus.inst2_pc_i[1:0],
                              bus.inst3_pc_i[63:IDX_W+2], bus.inst3_pc_i[1:0],
                              bus.viol_ld_pc_i[63:IDX_W+2], bus.viol_ld_pc_i[1:0],
                              bus.viol_st_pc_i[63:IDX_W+2], bus.viol_st_pc_i[1:0]};

    always_comb begin
        state_d  = state_q;
        ld_idx_d = ld_idx_q;
        st_idx_d = st_idx_q;
        alloc_d  = alloc_q;
        wr_ld    = 1'b0;
        wr_st    = 1'b0;
        wr_ssid  = '0;
        l_vld    = vld_q[ld_idx_q];
        s_vld    = vld_q[st_idx_q];
        l_ssid   = ssid_arr_q[ld_idx_q];
        s_ssid   = ssid_arr_q[st_idx_q];
        case (state_q)
            ST_IDLE: begin
                if (bus.viol_vld_i) begin
                    ld_idx_d = pc_idx(bus.viol_ld_pc_i);
                    st_idx_d = pc_idx(bus.viol_st_pc_i);
                    state_d  = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                // ld_idx==st_idx always lands in 00 or 11, so one alloc at most
                case ({l_vld, s_vld})
                    2'b00: begin
                        wr_ld   = 1'b1;
                        wr_st   = 1'b1;
                        wr_ssid = alloc_q;
                        alloc_d = alloc_q + 1'b1;
                    end
                    2'b10: begin
                        wr_st   = 1'b1;
                        wr_ssid = l_ssid;
                    end
                    2'b01: begin
                        wr_ld   = 1'b1;
                        wr_ssid = s_ssid;
                    end
                    default: begin
                        if (l_ssid != s_ssid) begin
                            wr_ld   = 1'b1;
                            wr_st   = 1'b1;
                            wr_ssid = ssid_min(l_ssid, s_ssid);
                        end
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
        // A clear drops the training write and the allocation it would consume
        if (clear_fire) begin
            wr_ld   = 1'b0;
            wr_st   = 1'b0;
            alloc_d = alloc_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ld_idx_q <= '0;
            st_idx_q <= '0;
            alloc_q  <= '0;
        end else begin
            state_q  <= state_d;
            ld_idx_q <= ld_idx_d;
            st_idx_q <= st_idx_d;
            alloc_q  <= alloc_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ssid_arr_q[i] <= '0;
            end
        end else if (clear_fire) begin
            vld_q <= '0;
        end else begin
            if (wr_ld) begin
                vld_q[ld_idx_q]      <= 1'b1;
                ssid_arr_q[ld_idx_q] <= wr_ssid;
            end
            if (wr_st) begin
                vld_q[st_idx_q]      <= 1'b1;
                ssid_arr_q[st_idx_q] <= wr_ssid;
            end
        end
    end

endmodule

// File: tb/tb_ssit.sv
// Self-checking bench for ssit: directed vector table, hand-written multi-cycle
// sequences and randomized reports checked against a store-set reference model.
module tb_ssit;
    import mdp_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ssit_if bus();
    ssit_if bus16();

    ssit #(.IDX_W(10), .CLEAR_PERIOD(65536)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    ssit #(.IDX_W(10), .CLEAR_PERIOD(16)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the table as plain arrays plus the next free store set.
    bit m_vld  [1024];
    int m_ssid [1024];
    int m_alloc;

    typedef struct {
        logic [63:0] ld;
        logic [63:0] st;
        logic [63:0] pa;
        int          ea;
        logic [63:0] pb;
        int          eb;
    } vec_t;

    vec_t tbl [8];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(logic [63:0] pc);
        return int'((pc >> 2) & 64'h3FF);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) m_vld[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        for (int i = 0; i < 1024; i++) m_ssid[i] = 0;
        m_alloc = 0;
    endtask

    task automatic model_train(logic [63:0] ld, logic [63:0] st);
        int l;
        int s;
        int m;
        l = idx_of(ld);
        s = idx_of(st);
        if (!m_vld[l] && !m_vld[s]) begin
            m_ssid[l] = m_alloc;
            m_ssid[s] = m_alloc;
            m_alloc   = (m_alloc + 1) % 128;
        end else if (m_vld[l] && !m_vld[s]) begin
            m_ssid[s] = m_ssid[l];
        end else if (!m_vld[l]) begin
            m_ssid[l] = m_ssid[s];
        end else if (m_ssid[l] != m_ssid[s]) begin
            m = (m_ssid[l] < m_ssid[s]) ? m_ssid[l] : m_ssid[s];
            m_ssid[l] = m;
            m_ssid[s] = m;
        end
        m_vld[l] = 1'b1;
        m_vld[s] = 1'b1;
    endtask

    task automatic set_pc(int slot, logic [63:0] pc);
        case (slot)
            0: bus.inst0_pc_i = pc;
            1: bus.inst1_pc_i = pc;
            2: bus.inst2_pc_i = pc;
            default: bus.inst3_pc_i = pc;
        endcase
    endtask

    function automatic logic get_vld(int slot);
        case (slot)
            0: return bus.inst0_ssid_vld_o;
            1: return bus.inst1_ssid_vld_o;
            2: return bus.inst2_ssid_vld_o;
            default: return bus.inst3_ssid_vld_o;
        endcase
    endfunction

    function automatic ssid_t get_ssid(int slot);
        case (slot)
            0: return bus.inst0_ssid_o;
            1: return bus.inst1_ssid_o;
            2: return bus.inst2_ssid_o;
            default: return bus.inst3_ssid_o;
        endcase
    endfunction

    task automatic expect_lookup(int slot, logic [63:0] pc, bit exp_vld, int exp_ssid, string name);
        set_pc(slot, pc);
        #1;
        check({name, "_vld"}, 64'(get_vld(slot)), 64'(exp_vld));
        if (exp_vld) check({name, "_ssid"}, 64'(get_ssid(slot)), 64'(exp_ssid));
    endtask

    task automatic model_lookup(int slot, logic [63:0] pc, string name);
        expect_lookup(slot, pc, m_vld[idx_of(pc)], m_ssid[idx_of(pc)], name);
    endtask

    // Starts and ends at a negedge; the report is trained once it returns.
    task automatic send_viol(logic [63:0] ld, logic [63:0] st);
        int n;
        n = 0;
        while (bus.viol_rdy_o !== 1'b1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        if (n == 8) check("viol_rdy_timeout", 64'(bus.viol_rdy_o), 64'd1);
        bus.viol_vld_i   = 1'b1;
        bus.viol_ld_pc_i = ld;
        bus.viol_st_pc_i = st;
        @(negedge clock);
        bus.viol_vld_i = 1'b0;
        @(negedge clock);
        model_train(ld, st);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a_ld, a_st, b_ld, b_st, pc_r, ld_r, st_r;
        int n;

        bus.inst0_pc_i = '0; bus.inst1_pc_i = '0; bus.inst2_pc_i = '0; bus.inst3_pc_i = '0;
        bus.viol_vld_i = 1'b0; bus.viol_ld_pc_i = '0; bus.viol_st_pc_i = '0; bus.clear_req_i = 1'b0;
        bus16.inst0_pc_i = '0; bus16.inst1_pc_i = '0; bus16.inst2_pc_i = '0; bus16.inst3_pc_i = '0;
        bus16.viol_vld_i = 1'b0; bus16.viol_ld_pc_i = '0; bus16.viol_st_pc_i = '0; bus16.clear_req_i = 1'b0;

        tbl[0] = '{64'h1010, 64'h2020, 64'h1010, 0, 64'h2020, 0};
        tbl[1] = '{64'h3030, 64'h4040, 64'h3030, 1, 64'h4040, 1};
        tbl[2] = '{64'h1010, 64'h4040, 64'h4040, 0, 64'h3030, 1};
        tbl[3] = '{64'h1010, 64'h5050, 64'h5050, 0, 64'h1010, 0};
        tbl[4] = '{64'h6060, 64'h3030, 64'h6060, 1, 64'h3030, 1};
        tbl[5] = '{64'h1010, 64'h2020, 64'h1010, 0, 64'h2020, 0};
        tbl[6] = '{64'h7070, 64'h7070, 64'h7070, 2, 64'h7070, 2};
        tbl[7] = '{64'h8080, 64'h9090, 64'h8080, 3, 64'h9090, 3};

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);

        for (int s = 0; s < 4; s++) expect_lookup(s, 64'h1000 + 64'(s * 4), 1'b0, 0, "reset_lookup");
        check("reset_rdy", 64'(bus.viol_rdy_o), 64'd1);
        check("reset_clear_o", 64'(bus.clear_o), 64'd0);

        foreach (tbl[i]) begin
            send_viol(tbl[i].ld, tbl[i].st);
            expect_lookup(i % 4, tbl[i].pa, 1'b1, tbl[i].ea, $sformatf("tbl%0d_a", i));
            expect_lookup((i + 1) % 4, tbl[i].pb, 1'b1, tbl[i].eb, $sformatf("tbl%0d_b", i));
        end

        // Back-to-back reports: second one held during UPDATE
        a_ld = 64'hA00; a_st = 64'hC08; b_ld = 64'hB04; b_st = 64'hD0C;
        bus.viol_vld_i = 1'b1; bus.viol_ld_pc_i = a_ld; bus.viol_st_pc_i = a_st;
        @(negedge clock);
        check("b2b_rdy_update", 64'(bus.viol_rdy_o), 64'd0);
        expect_lookup(0, a_ld, 1'b0, 0, "write_not_visible_same_cycle");
        bus.viol_ld_pc_i = b_ld; bus.viol_st_pc_i = b_st;
        @(negedge clock);
        check("b2b_rdy_idle", 64'(bus.viol_rdy_o), 64'd1);
        model_train(a_ld, a_st);
        @(negedge clock);
        bus.viol_vld_i = 1'b0;
        check("b2b_rdy_second_update", 64'(bus.viol_rdy_o), 64'd0);
        @(negedge clock);
        model_train(b_ld, b_st);
        model_lookup(0, a_ld, "b2b_a_ld");
        model_lookup(1, a_st, "b2b_a_st");
        model_lookup(2, b_ld, "b2b_b_ld");
        model_lookup(3, b_st, "b2b_b_st");
        expect_lookup(3, b_st, 1'b1, 5, "b2b_b_alloc");

        // Clear during UPDATE drops the write
        bus.viol_vld_i = 1'b1; bus.viol_ld_pc_i = 64'hE10; bus.viol_st_pc_i = 64'hF14;
        @(negedge clock);
        bus.viol_vld_i = 1'b0; bus.clear_req_i = 1'b1;
        @(negedge clock);
        bus.clear_req_i = 1'b0;
        model_clear();
        check("clr_upd_clear_o", 64'(bus.clear_o), 64'd1);
        check("clr_upd_rdy", 64'(bus.viol_rdy_o), 64'd1);
        model_lookup(0, 64'hE10, "clr_upd_ld");
        model_lookup(1, 64'hF14, "clr_upd_st");
        model_lookup(2, 64'h1010, "clr_upd_old");
        @(negedge clock);
        check("clr_one_cycle", 64'(bus.clear_o), 64'd0);

        // Report accepted in the clear cycle still trains afterwards
        bus.viol_vld_i = 1'b1; bus.viol_ld_pc_i = 64'h1010; bus.viol_st_pc_i = 64'h2020;
        bus.clear_req_i = 1'b1;
        @(negedge clock);
        bus.viol_vld_i = 1'b0; bus.clear_req_i = 1'b0;
        model_clear();
        check("clr_acc_clear_o", 64'(bus.clear_o), 64'd1);
        @(negedge clock);
        model_train(64'h1010, 64'h2020);
        model_lookup(0, 64'h1010, "clr_acc_ld");
        expect_lookup(1, 64'h2020, 1'b1, 6, "clr_acc_alloc_kept");

        // Held request clears every cycle
        bus.clear_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("clr_held_%0d", i), 64'(bus.clear_o), 64'd1);
        end
        bus.clear_req_i = 1'b0;
        model_clear();
        @(negedge clock);
        check("clr_held_release", 64'(bus.clear_o), 64'd0);
        model_lookup(0, 64'h1010, "clr_held_lookup");

        // Randomized reports over a small PC pool so sets merge
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                bus.clear_req_i = 1'b1;
                @(negedge clock);
                bus.clear_req_i = 1'b0;
                model_clear();
                check("rand_clear_o", 64'(bus.clear_o), 64'd1);
            end else begin
                ld_r = 64'h8000_0000 + 64'($urandom_range(0, 23) * 4);
                st_r = 64'h8000_0000 + 64'($urandom_range(0, 23) * 4);
                pc_r = 64'h8000_0000 + 64'($urandom_range(0, 23) * 4);
                send_viol(ld_r, st_r);
                model_lookup(it % 4, ld_r, "rand_ld");
                model_lookup((it + 1) % 4, st_r, "rand_st");
                model_lookup((it + 2) % 4, pc_r, "rand_other");
            end
        end

        // Reset in UPDATE loses the report
        bus.viol_vld_i = 1'b1; bus.viol_ld_pc_i = 64'h1010; bus.viol_st_pc_i = 64'h2020;
        @(negedge clock);
        bus.viol_vld_i = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_upd_rdy", 64'(bus.viol_rdy_o), 64'd1);
        check("rst_upd_clear_o", 64'(bus.clear_o), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
        expect_lookup(0, 64'h1010, 1'b0, 0, "rst_upd_lost");

        // 129 fresh disjoint pairs wrap the allocator
        for (int k = 0; k < 129; k++) send_viol(64'(k * 8), 64'(k * 8 + 4));
        expect_lookup(0, 64'd0, 1'b1, 0, "wrap_pair0");
        expect_lookup(1, 64'(127 * 8 + 4), 1'b1, 127, "wrap_pair127");
        expect_lookup(2, 64'(128 * 8), 1'b1, 0, "wrap_pair128_ld");
        expect_lookup(3, 64'(128 * 8 + 4), 1'b1, 0, "wrap_pair128_st");
        model_lookup(0, 64'(64 * 8), "wrap_model_mid");

        // Periodic clear with CLEAR_PERIOD=16
        n = 0;
        while (bus16.clear_o !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("p16_first_pulse", 64'(n < 40), 64'd1);
        for (int r = 0; r < 3; r++) begin
            @(negedge clock);
            check($sformatf("p16_width_%0d", r), 64'(bus16.clear_o), 64'd0);
            n = 1;
            while (bus16.clear_o !== 1'b1 && n < 40) begin
                @(negedge clock);
                n++;
            end
            check($sformatf("p16_interval_%0d", r), 64'(n), 64'd16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
